// File: rtl/bip_defs.sv
// Shared constants for the BIP sequencer: opcodes, FSM state codes and datapath select encodings.
package bip_defs;

   localparam logic [4:0] OP_HLT  = 5'b00000;
   localparam logic [4:0] OP_STO  = 5'b00001;
   localparam logic [4:0] OP_LD   = 5'b00010;
   localparam logic [4:0] OP_LDI  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   localparam logic [1:0] SEL_A_MEM = 2'b00;
   localparam logic [1:0] SEL_A_IMM = 2'b01;
   localparam logic [1:0] SEL_A_ALU = 2'b10;
   localparam logic       SEL_B_MEM = 1'b0;
   localparam logic       SEL_B_IMM = 1'b1;
   localparam logic       ALU_ADD   = 1'b0;
   localparam logic       ALU_SUB   = 1'b1;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decode; strobes are ungated here and qualified by state in the controller.
module bip_decoder
   import bip_defs::*;
(
   input  logic [4:0] opcode_i,
   output logic       wr_ram_o,
   output logic       rd_ram_o,
   output logic       wr_acc_o,
   output logic [1:0] sel_a_o,
   output logic       sel_b_o,
   output logic       alu_op_o,
   output logic       is_halt_o
);

   always_comb begin
      wr_ram_o  = 1'b0;
      rd_ram_o  = 1'b0;
      wr_acc_o  = 1'b0;
      sel_a_o   = SEL_A_MEM;
      sel_b_o   = SEL_B_MEM;
      alu_op_o  = ALU_ADD;
      is_halt_o = 1'b0;
      case (opcode_i)
         OP_HLT:  is_halt_o = 1'b1;
         OP_STO:  wr_ram_o  = 1'b1;
         OP_LD: begin
            rd_ram_o = 1'b1;
            wr_acc_o = 1'b1;
         end
         OP_LDI: begin
            wr_acc_o = 1'b1;
            sel_a_o  = SEL_A_IMM;
         end
         OP_ADD: begin
            rd_ram_o = 1'b1;
            wr_acc_o = 1'b1;
            sel_a_o  = SEL_A_ALU;
         end
         OP_ADDI: begin
            wr_acc_o = 1'b1;
            sel_a_o  = SEL_A_ALU;
            sel_b_o  = SEL_B_IMM;
         end
         OP_SUB: begin
            rd_ram_o = 1'b1;
            wr_acc_o = 1'b1;
            sel_a_o  = SEL_A_ALU;
            alu_op_o = ALU_SUB;
         end
         OP_SUBI: begin
            wr_acc_o = 1'b1;
            sel_a_o  = SEL_A_ALU;
            sel_b_o  = SEL_B_IMM;
            alu_op_o = ALU_SUB;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bip_control.sv
// BIP sequencer: owns the PC, runs FETCH/DECODE/EXEC per instruction and issues one-cycle datapath strobes.
module bip_control
   import bip_defs::*;
#(
   parameter int ADDR_LENGTH   = 11,
   parameter int OPCODE_LENGTH = 5,
   parameter int INSTR_LENGTH  = OPCODE_LENGTH + ADDR_LENGTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic [ADDR_LENGTH-1:0]  pm_addr,
   input  logic [INSTR_LENGTH-1:0] pm_instruction,
   output logic [ADDR_LENGTH-1:0]  operand,
   output logic                    rd_ram,
   output logic                    wr_ram,
   output logic                    wr_acc,
   output logic [1:0]              sel_a,
   output logic                    sel_b,
   output logic                    alu_op,
   output logic                    halted,
   output logic [15:0]             instr_count
);

   logic [2:0]              state_q, state_d;
   logic [ADDR_LENGTH-1:0]  pc_q, pc_d;
   logic [INSTR_LENGTH-1:0] ir_q, ir_d;
   logic [15:0]             cnt_q, cnt_d;

   logic                    in_decode, in_exec, acc_write;
   logic [INSTR_LENGTH-1:0] instr_cur;
   logic                    dec_wr_ram, dec_rd_ram, dec_wr_acc, dec_sel_b, dec_alu_op, dec_halt;
   logic [1:0]              dec_sel_a;

   assign in_decode = (state_q == ST_DECODE);
   assign in_exec   = (state_q == ST_EXEC);

   // The IR is only loaded at the end of DECODE, so during DECODE the live memory word stands in for it.
   assign instr_cur = in_decode ? pm_instruction : ir_q;

   bip_decoder u_decoder (
      .opcode_i  (instr_cur[INSTR_LENGTH-1 -: 5]),
      .wr_ram_o  (dec_wr_ram),
      .rd_ram_o  (dec_rd_ram),
      .wr_acc_o  (dec_wr_acc),
      .sel_a_o   (dec_sel_a),
      .sel_b_o   (dec_sel_b),
      .alu_op_o  (dec_alu_op),
      .is_halt_o (dec_halt)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            ir_d    = pm_instruction;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (dec_halt) begin
               state_d = ST_HALT;
            end else begin
               pc_d    = pc_q + {{(ADDR_LENGTH-1){1'b0}}, 1'b1};
               state_d = ST_FETCH;
            end
         end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobes are derived from the registered state so an asynchronous reset kills them immediately.
   assign acc_write   = in_exec & dec_wr_acc;
   assign pm_addr     = pc_q;
   assign operand     = instr_cur[ADDR_LENGTH-1:0];
   assign rd_ram      = in_decode & dec_rd_ram;
   assign wr_ram      = in_exec & dec_wr_ram;
   assign wr_acc      = acc_write;
   assign sel_a       = acc_write ? dec_sel_a : SEL_A_MEM;
   assign sel_b       = acc_write & dec_sel_b;
   assign alu_op      = acc_write & dec_alu_op;
   assign halted      = (state_q == ST_HALT);
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: directed programs plus random programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_bip_control;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] pm_addr;
   logic [15:0] pm_instruction = 16'h0000;
   logic [10:0] operand;
   logic        rd_ram, wr_ram, wr_acc, sel_b, alu_op, halted;
   logic [1:0]  sel_a;
   logic [15:0] instr_count;

   logic [15:0] mem [0:2047];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_pc   = 0;
   int          exp_cnt  = 0;

   bip_control dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .pm_addr        (pm_addr),
      .pm_instruction (pm_instruction),
      .operand        (operand),
      .rd_ram         (rd_ram),
      .wr_ram         (wr_ram),
      .wr_acc         (wr_acc),
      .sel_a          (sel_a),
      .sel_b          (sel_b),
      .alu_op         (alu_op),
      .halted         (halted),
      .instr_count    (instr_count)
   );

   always #5 clk = ~clk;

   // Synchronous program memory with one cycle of read latency.
   always @(posedge clk) pm_instruction <= mem[pm_addr];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opd);
      return {op, opd};
   endfunction

   // Expected EXEC strobes {wr_ram, wr_acc, sel_a, sel_b, alu_op} straight from the opcode table.
   function automatic logic [5:0] exp_exec(input logic [4:0] op);
      case (op)
         5'd1:    return 6'b10_00_0_0;
         5'd2:    return 6'b01_00_0_0;
         5'd3:    return 6'b01_01_0_0;
         5'd4:    return 6'b01_10_0_0;
         5'd5:    return 6'b01_10_1_0;
         5'd6:    return 6'b01_10_0_1;
         5'd7:    return 6'b01_10_1_1;
         default: return 6'b00_00_0_0;
      endcase
   endfunction

   function automatic logic exp_rd(input logic [4:0] op);
      return (op == 5'd2) || (op == 5'd4) || (op == 5'd6);
   endfunction

   task automatic fill(input logic [15:0] w);
      for (int i = 0; i < 2048; i++) mem[i] = w;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset_pm_addr", 32'(pm_addr), 32'd0);
      chk("reset_outputs", 32'({rd_ram, wr_ram, wr_acc, sel_a, sel_b, alu_op, halted}), 32'd0);
      chk("reset_count", 32'(instr_count), 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      exp_pc  = 0;
      exp_cnt = 0;
   endtask

   // Pulses start, then follows up to 'limit' instructions; returns in HALT or at the next FETCH.
   task automatic run_prog(input int limit);
      logic [15:0] ins;
      logic [4:0]  op;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < limit; k++) begin
         ins = mem[exp_pc];
         op  = ins[15:11];
         chk("fetch_pm_addr", 32'(pm_addr), 32'(exp_pc));
         chk("fetch_quiet", 32'({rd_ram, wr_ram, wr_acc, halted}), 32'd0);
         chk("fetch_count", 32'(instr_count), 32'(exp_cnt));
         tick();
         chk("decode_rd_ram", 32'(rd_ram), 32'(exp_rd(op)));
         chk("decode_operand", 32'(operand), 32'(ins[10:0]));
         chk("decode_quiet", 32'({wr_ram, wr_acc, halted}), 32'd0);
         tick();
         chk("exec_strobes", 32'({wr_ram, wr_acc, sel_a, sel_b, alu_op}), 32'(exp_exec(op)));
         chk("exec_rd_low", 32'(rd_ram), 32'd0);
         chk("exec_operand", 32'(operand), 32'(ins[10:0]));
         $display("instr pc=%03h op=%02h operand=%03h count=%0d", exp_pc, op, ins[10:0], exp_cnt + 1);
         if (exp_cnt < 65535) exp_cnt++;
         tick();
         if (op == 5'd0) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_pm_addr", 32'(pm_addr), 32'(exp_pc));
            chk("halt_count", 32'(instr_count), 32'(exp_cnt));
            return;
         end
         exp_pc = (exp_pc + 1) % 2048;
      end
   endtask

   initial begin
      int n;
      logic [4:0] op;
      reset = 1'b1;
      start = 1'b0;
      fill(16'h0000);
      do_reset();

      // Idle with start low: nothing moves.
      repeat (3) begin
         tick();
         chk("idle_pm_addr", 32'(pm_addr), 32'd0);
         chk("idle_quiet", 32'({rd_ram, wr_ram, wr_acc, halted}), 32'd0);
      end

      // LDI 5; ADDI 3; STO 0x10; HLT
      mem[0] = enc(5'd3, 11'd5);
      mem[1] = enc(5'd5, 11'd3);
      mem[2] = enc(5'd1, 11'h010);
      mem[3] = enc(5'd0, 11'd0);
      run_prog(10);
      chk("prog1_count", 32'(instr_count), 32'd4);

      // Start is ignored in HALT.
      for (int i = 0; i < 10; i++) begin
         start = i[0];
         tick();
         chk("halt_hold_flag", 32'(halted), 32'd1);
         chk("halt_hold_addr", 32'(pm_addr), 32'd3);
         chk("halt_hold_quiet", 32'({rd_ram, wr_ram, wr_acc, sel_a, sel_b, alu_op}), 32'd0);
         chk("halt_hold_count", 32'(instr_count), 32'd4);
      end
      start = 1'b0;

      // LD 0x20; SUB 0x21; HLT
      fill(16'h0000);
      mem[0] = enc(5'd2, 11'h020);
      mem[1] = enc(5'd6, 11'h021);
      do_reset();
      run_prog(10);

      // Unknown opcode behaves as a NOP.
      fill(16'h0000);
      mem[0] = enc(5'b11111, 11'h155);
      do_reset();
      run_prog(10);
      chk("nop_count", 32'(instr_count), 32'd2);

      // Asynchronous reset during STO EXEC.
      fill(16'h0000);
      mem[0] = enc(5'd1, 11'h010);
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("sto_exec_wr_ram", 32'(wr_ram), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_wr_ram", 32'(wr_ram), 32'd0);
      chk("async_pm_addr", 32'(pm_addr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) begin
         tick();
         chk("post_reset_idle", 32'({pm_addr, wr_ram, wr_acc, rd_ram}), 32'd0);
         chk("post_reset_count", 32'(instr_count), 32'd0);
      end
      exp_pc  = 0;
      exp_cnt = 0;
      run_prog(10);

      // Random programs against the instruction-level model.
      for (int r = 0; r < 6; r++) begin
         fill(16'h0000);
         n = $urandom_range(3, 12);
         for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(1, 7)) : 5'($urandom_range(8, 31));
            mem[i] = enc(op, 11'($urandom_range(0, 2047)));
         end
         do_reset();
         repeat ($urandom_range(0, 3)) tick();
         run_prog(n + 1);
         chk("rand_count", 32'(instr_count), 32'(n + 1));
      end

      // PC wraps from 0x7FF to 0x000.
      fill(enc(5'b01000, 11'h0AA));
      mem[0] = enc(5'd3, 11'h07F);
      do_reset();
      run_prog(2049);
      chk("wrap_pm_addr", 32'(pm_addr), 32'd1);
      chk("wrap_count", 32'(instr_count), 32'd2049);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
